mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- Parametrised N-port arbiter between the cache-side memory ports (I-cache, D-cache, optional prefetch/victim buffer) and the single physical memory port.
- Replaces the fixed 2-way select with a registered request/grant FSM.
- Provides round-robin fairness, per-port one-cycle responses and a transaction watchdog.
- Sits between the L1 caches (or L2) and the cacheline adaptor.

Parameters:
NUM_PORTS, 2, number of requesting ports (2..8)
ADDR_WIDTH, 32, physical address width
LINE_WIDTH, 256, cacheline width in bits
TIMEOUT_CYCLES, 1023, max cycles in BUSY before timeout; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_read  in  NUM_PORTS  per-port read request, held until that port's resp
req_write  in  NUM_PORTS  per-port write request, held until that port's resp
req_addr  in  NUM_PORTS x ADDR_WIDTH  per-port line address
req_wdata  in  NUM_PORTS x LINE_WIDTH  per-port write line
req_rdata  out  LINE_WIDTH  read line, shared by all ports, valid with resp
req_resp  out  NUM_PORTS  one-hot completion pulse
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_addr  out  ADDR_WIDTH  memory address
pmem_wdata  out  LINE_WIDTH  memory write line
pmem_rdata  in  LINE_WIDTH  memory read line
pmem_resp  in  1  memory completion
grant_id  out  clog2(NUM_PORTS)  currently granted port (debug/perf)
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: state IDLE, rr_ptr 0, grant_id 0, pmem_read/pmem_write 0, pmem_addr 0, pmem_wdata 0, req_resp 0, req_rdata 0, timeout_err 0, watchdog counter 0. Reset is asynchronous; asserting it mid-transaction drops the strobes immediately. No resp is issued for the aborted transaction.
- A port is requesting when req_read | req_write. If both are high, the port is treated as a write (illegal combination; the assertion flags it).
- FSM states: IDLE, BUSY, DONE.
- IDLE: pick the first requesting port scanning from rr_ptr upward, modulo NUM_PORTS. On an edge with any request:
  - register grant_id, op (read/write), addr and wdata from that port;
  - go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - pmem_read/pmem_write are driven from the registered op; pmem_addr/pmem_wdata come from the registered copies. Outputs are stable for the whole transaction regardless of requester changes.
  - Strobes rise the cycle after the grant edge, so min 1 cycle request-to-strobe latency.
  - When pmem_resp=1: req_resp[grant_id]=1 combinationally in that same cycle, and req_rdata=pmem_rdata (pass-through); all other req_resp bits stay 0.
  - On that edge go to DONE and set rr_ptr = grant_id+1 (wraps to 0 at NUM_PORTS).
- DONE: one bubble cycle, strobes 0, req_resp 0, then IDLE. This lets the served requester drop its request, so it is never double-granted.
- Watchdog: counts cycles in BUSY and clears on leaving BUSY. When the count reaches TIMEOUT_CYCLES without pmem_resp:
  - set timeout_err (sticky until reset);
  - pulse req_resp[grant_id] with req_rdata=0;
  - go to DONE.
- If pmem_resp arrives on the same cycle as the timeout, it wins as a normal completion.
- Simultaneous requests are resolved purely by rr_ptr. A port that is requesting is served within NUM_PORTS transactions.
- req_rdata holds its last value outside resp cycles (registered mux hold). Consumers sample it only with resp.
- NUM_PORTS=1 degenerates to pass-through with the IDLE/BUSY/DONE sequence. grant_id is then width 1 and tied to 0.

Decomposition:
- Package mem_arbiter_pkg holds:
  - arb_state_t enum {IDLE, BUSY, DONE};
  - the op_t enum {OP_READ, OP_WRITE};
  - localparam helper for the grant index width, $clog2 with minimum 1.
- One sub-module, rr_priority_pick: combinational find-first-set rotated by rr_ptr. Inputs req vector and ptr; outputs valid and index.
- The FSM, capture registers and watchdog live in mem_arbiter_rr.

Test Plan:
- Reset then single request, NUM_PORTS=2: port0 read addr 0x0000_1000, memory resp after 4 cycles with 0xAA..AA → one pmem_read burst, pmem_addr 0x1000, req_resp=2'b01 for exactly 1 cycle, req_rdata=0xAA..AA.
- Contention, NUM_PORTS=3: all ports request reads from the same edge and hold until served → service order 0,1,2; port 0 re-requests after its resp and is served after 2, not before 1.
- Write path: port1 write addr 0x0000_2040, wdata pattern 0x1234.. → pmem_write=1, pmem_addr=0x2040, pmem_wdata=pattern stable all BUSY cycles even if req_wdata changes mid-transaction; pmem_read=0 throughout.
- Watchdog: TIMEOUT_CYCLES=8, pmem_resp never asserts → resp pulse on the granted port 8 cycles into BUSY, req_rdata=0, timeout_err=1 and still 1 after later good transactions.
- Async reset mid-BUSY: drop rst_n between clock edges while pmem_read=1 → pmem_read=0 immediately, no req_resp, rr_ptr=0; after release a pending port1 request is served normally.
- Back-to-back single port: port0 deasserts read after resp and reasserts 1 cycle later → exactly one DONE bubble, no duplicate resp, second grant proceeds.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and sizing helpers for the round-robin memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_priority_pick: find-first-set over req, scanning upward from ptr with wrap.
module rr_priority_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  assign valid = |req;
  // Walk offsets from farthest to nearest so the closest request to ptr wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = W'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin N-port arbiter onto one cacheline memory port.
// Registered IDLE/BUSY/DONE handshake with a sticky transaction watchdog.
module mem_arbiter_rr
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int GW = idx_width(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata,
  output logic [LINE_WIDTH-1:0]                req_rdata,
  output logic [NUM_PORTS-1:0]                 req_resp,
  output logic                                 pmem_read,
  output logic                                 pmem_write,
  output logic [ADDR_WIDTH-1:0]                pmem_addr,
  output logic [LINE_WIDTH-1:0]                pmem_wdata,
  input  logic [LINE_WIDTH-1:0]                pmem_rdata,
  input  logic                                 pmem_resp,
  output logic [GW-1:0]                        grant_id,
  output logic                                 timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  arb_state_t state;
  logic [GW-1:0] rr_ptr, pick_idx, next_ptr;
  logic pick_valid, busy, timeout, fire;
  logic [TW-1:0] wd_cnt;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic [NUM_PORTS-1:0] req_any;
  op_t pick_op;
  assign req_any = req_read | req_write;
  rr_priority_pick #(.N(NUM_PORTS), .W(GW)) u_pick (
    .req  (req_any),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
  // A port raising both strobes is treated as a write.
  assign pick_op = req_write[pick_idx] ? OP_WRITE : OP_READ;
  assign busy = state == BUSY;
  assign timeout = TIMEOUT_CYCLES != 0 && busy && int'(wd_cnt) + 1 == TIMEOUT_CYCLES;
  assign fire = busy && (pmem_resp || timeout);
  assign req_resp = fire ? NUM_PORTS'(1) << grant_id : '0;
  // A genuine completion wins over a timeout landing on the same cycle.
  assign req_rdata = fire ? (pmem_resp ? pmem_rdata : '0) : rdata_q;
  assign next_ptr = (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr <= '0;
      pmem_wdata <= '0;
      rdata_q <= '0;
      timeout_err <= 1'b0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          state <= BUSY;
          grant_id <= pick_idx;
          pmem_read <= pick_op == OP_READ;
          pmem_write <= pick_op == OP_WRITE;
          pmem_addr <= req_addr[pick_idx];
          pmem_wdata <= req_wdata[pick_idx];
          wd_cnt <= '0;
        end
        BUSY: if (fire) begin
          state <= DONE;
          pmem_read <= 1'b0;
          pmem_write <= 1'b0;
          rr_ptr <= next_ptr;
          rdata_q <= req_rdata;
          wd_cnt <= '0;
          if (!pmem_resp) timeout_err <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  no_read_and_write: assert property (@(posedge clk) disable iff (!rst_n) !(|(req_read & req_write)));
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed table, corner sequences and a randomized round-robin scoreboard.
module tb_mem_arbiter_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] req_read = '0, req_write = '0;
  logic [2:0][31:0] req_addr = '0;
  logic [2:0][255:0] req_wdata = '0;
  logic [255:0] req_rdata, pmem_wdata, pmem_rdata = '0;
  logic [2:0] req_resp;
  logic pmem_read, pmem_write, pmem_resp = 1'b0, timeout_err;
  logic [31:0] pmem_addr;
  logic [1:0] grant_id;
  int total = 0, bad = 0;
  int mem_cnt = 0, mem_lat = 1;
  bit mem_dead = 0, mem_rand = 0;
  logic [255:0] mem_data = '0;

  mem_arbiter_rr #(.NUM_PORTS(3), .ADDR_WIDTH(32), .LINE_WIDTH(256), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(req_rdata), .req_resp(req_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int rr_pick(input logic [2:0] r, input int ptr);
    for (int k = 0; k < 3; k++) if (r[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responds in the mem_lat-th cycle a strobe is seen; rdata is garbage otherwise.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (pmem_read | pmem_write) mem_cnt++;
    else begin
      mem_cnt = 0;
      if (mem_rand) mem_lat = $urandom_range(1, 5);
    end
    if (mem_rand && mem_cnt == 1) mem_data = rand256();
    pmem_resp = !mem_dead && mem_cnt != 0 && mem_cnt == mem_lat;
    pmem_rdata = pmem_resp ? mem_data : rand256();
    #1;
  endtask

  task automatic serve(input int p, input bit wr, input logic [31:0] a, input logic [255:0] wd,
                       input int lat, input logic [255:0] exp_rd, output int waited);
    int n;
    waited = 0;
    while (!(pmem_read | pmem_write) && waited < 20) begin
      chk("idle_noresp", req_resp, 0);
      tick();
      waited++;
    end
    chk("grant_id", grant_id, p);
    n = 1;
    while (req_resp == 0 && n < 20) begin
      chk("busy_op", {pmem_read, pmem_write}, wr ? 2'b01 : 2'b10);
      chk("busy_addr", pmem_addr, a);
      if (wr) chk("busy_wdata", pmem_wdata, wd);
      req_addr[p] = $urandom;
      req_wdata[p] = ~wd;
      tick();
      n++;
    end
    chk("resp_cycle", n, lat);
    chk("resp_onehot", req_resp, 3'b001 << p);
    chk("resp_rdata", req_rdata, exp_rd);
    req_read[p] = 1'b0;
    req_write[p] = 1'b0;
    tick();
    chk("done_strobe", {pmem_read, pmem_write}, 0);
    chk("done_resp", req_resp, 0);
    chk("rdata_hold", req_rdata, exp_rd);
  endtask

  typedef struct {
    int port; bit wr; logic [31:0] addr; logic [255:0] wdata;
    int lat; bit dead; logic [255:0] mdata; logic [255:0] exp_rd; bit exp_to;
  } vec_t;
  vec_t vt[6];

  int w, cur, exp_ptr, gap, ntx;
  int hold[3];
  bit active, exp_next, e_wr, strobe, nw;
  logic [31:0] e_addr;
  logic [255:0] e_wd;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr", pmem_addr, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_req_resp", req_resp, 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout_err", timeout_err, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Contention: all three read together; port 0 re-requests and must wait behind 1 and 2.
    mem_lat = 3;
    mem_data = {8{32'hC0DE_0001}};
    for (int p = 0; p < 3; p++) begin
      req_addr[p] = 32'h3000 + 32'(p * 64);
      req_read[p] = 1'b1;
    end
    serve(0, 0, 32'h3000, '0, 3, mem_data, w);
    req_addr[0] = 32'h30C0;
    req_read[0] = 1'b1;
    serve(1, 0, 32'h3040, '0, 3, mem_data, w);
    serve(2, 0, 32'h3080, '0, 3, mem_data, w);
    serve(0, 0, 32'h30C0, '0, 3, mem_data, w);

    vt[0] = '{0, 1'b0, 32'h0000_1000, '0, 4, 1'b0, {8{32'hAAAA_AAAA}}, {8{32'hAAAA_AAAA}}, 1'b0};
    vt[1] = '{1, 1'b1, 32'h0000_2040, {8{32'h1234_5678}}, 3, 1'b0, {8{32'h5555_0000}}, {8{32'h5555_0000}}, 1'b0};
    vt[2] = '{2, 1'b0, 32'h0000_2080, '0, 1, 1'b0, {8{32'hDC3D_C3DC}}, {8{32'hDC3D_C3DC}}, 1'b0};
    vt[3] = '{0, 1'b1, 32'h0000_20C0, {8{32'hFEED_BEEF}}, 5, 1'b0, {8{32'h0F0F_0F0F}}, {8{32'h0F0F_0F0F}}, 1'b0};
    vt[4] = '{1, 1'b0, 32'h0000_4000, '0, 8, 1'b1, {8{32'h7777_7777}}, '0, 1'b1};
    vt[5] = '{2, 1'b0, 32'h0000_4040, '0, 2, 1'b0, {8{32'h9999_1111}}, {8{32'h9999_1111}}, 1'b1};
    for (int i = 0; i < 6; i++) begin
      mem_lat = vt[i].lat;
      mem_dead = vt[i].dead;
      mem_data = vt[i].mdata;
      req_addr[vt[i].port] = vt[i].addr;
      req_wdata[vt[i].port] = vt[i].wdata;
      req_read[vt[i].port] = !vt[i].wr;
      req_write[vt[i].port] = vt[i].wr;
      serve(vt[i].port, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].lat, vt[i].exp_rd, w);
      chk("timeout_err", timeout_err, vt[i].exp_to);
    end
    mem_dead = 1'b0;

    // Async reset mid-BUSY: pointer sits at 2 beforehand, so port 1 winning afterwards shows it cleared.
    mem_lat = 2;
    mem_data = {8{32'h5151_5151}};
    req_addr[1] = 32'h5000;
    req_read[1] = 1'b1;
    serve(1, 0, 32'h5000, '0, 2, mem_data, w);
    mem_lat = 6;
    req_addr[2] = 32'h5040;
    req_read[2] = 1'b1;
    w = 0;
    while (!pmem_read && w < 20) begin
      tick();
      w++;
    end
    chk("ar_grant", grant_id, 2);
    req_addr[1] = 32'h5080;
    req_read[1] = 1'b1;
    tick();
    chk("ar_pre_read", pmem_read, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_read", pmem_read, 0);
    chk("ar_resp", req_resp, 0);
    chk("ar_grant0", grant_id, 0);
    chk("ar_timeout", timeout_err, 0);
    tick();
    chk("ar_hold_resp", req_resp, 0);
    chk("ar_hold_read", pmem_read, 0);
    rst_n = 1'b1;
    serve(1, 0, 32'h5080, '0, 6, mem_data, w);
    serve(2, 0, 32'h5040, '0, 6, mem_data, w);

    // Back-to-back on one port: one DONE bubble plus the IDLE grant cycle.
    mem_lat = 2;
    req_addr[0] = 32'h6000;
    req_read[0] = 1'b1;
    serve(0, 0, 32'h6000, '0, 2, mem_data, w);
    req_addr[0] = 32'h6040;
    req_read[0] = 1'b1;
    serve(0, 0, 32'h6040, '0, 2, mem_data, w);
    chk("b2b_gap", w, 2);

    // Randomized traffic against a transaction-level round-robin scoreboard.
    rst_n = 1'b0;
    req_read = '0;
    req_write = '0;
    #1;
    tick();
    rst_n = 1'b1;
    mem_rand = 1'b1;
    active = 0;
    exp_next = 0;
    gap = 2;
    exp_ptr = 0;
    ntx = 0;
    cur = 0;
    for (int p = 0; p < 3; p++) hold[p] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      strobe = pmem_read | pmem_write;
      if (exp_next) begin
        chk("rnd_start", strobe, 1);
        chk("rnd_grant", grant_id, cur);
        active = 1;
      end else if (!active) chk("rnd_idle", strobe, 0);
      if (active) begin
        chk("rnd_addr", pmem_addr, e_addr);
        chk("rnd_op", {pmem_read, pmem_write}, e_wr ? 2'b01 : 2'b10);
        if (e_wr) chk("rnd_wdata", pmem_wdata, e_wd);
        if (pmem_resp) begin
          chk("rnd_resp", req_resp, 3'b001 << cur);
          chk("rnd_rdata", req_rdata, pmem_rdata);
          req_read[cur] = 1'b0;
          req_write[cur] = 1'b0;
          hold[cur] = $urandom_range(0, 3);
          exp_ptr = (cur + 1) % 3;
          active = 0;
          gap = 0;
          ntx++;
        end else begin
          chk("rnd_noresp", req_resp, 0);
          req_addr[cur] = $urandom;
          req_wdata[cur] = rand256();
        end
      end else begin
        chk("rnd_quiet", req_resp, 0);
        gap++;
      end
      for (int p = 0; p < 3; p++)
        if (!(req_read[p] | req_write[p])) begin
          if (hold[p] > 0) hold[p]--;
          else if ($urandom_range(0, 1) == 1) begin
            nw = 1'($urandom_range(0, 1));
            req_write[p] = nw;
            req_read[p] = !nw;
            req_addr[p] = $urandom & 32'hFFFF_FFC0;
            req_wdata[p] = rand256();
          end
        end
      exp_next = !active && gap >= 2 && (req_read | req_write) != 0;
      if (exp_next) begin
        cur = rr_pick(req_read | req_write, exp_ptr);
        e_addr = req_addr[cur];
        e_wr = req_write[cur];
        e_wd = req_wdata[cur];
      end
      tick();
    end
    chk("rnd_activity", ntx > 30, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
